// File: rtl/arc4_pkg.sv
// Shared types for the ARC4 decrypt sequencer: FSM states, phase encoding, key width.
package arc4_pkg;

  localparam int KEY_W_DEF = 24;

  typedef enum logic [2:0] {
    IDLE,
    GO_INIT,
    RUN_INIT,
    GO_KSA,
    RUN_KSA,
    GO_PRGA,
    RUN_PRGA
  } sched_state_t;

  // Phase doubles as the S-port owner select and the LEDR status code.
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_INIT = 2'd1,
    PH_KSA  = 2'd2,
    PH_PRGA = 2'd3
  } phase_t;

endpackage

// File: rtl/arc4_sched_if.sv
// Bundle of the request handshake, engine handshakes and S-memory port seen by arc4_sched.
interface arc4_sched_if #(
  parameter int KEY_W = arc4_pkg::KEY_W_DEF
);
  import arc4_pkg::*;

  // Request handshake: en is taken only in a cycle where rdy=1; rdy drops the
  // cycle after acceptance and rises again when the whole job is complete.
  // Engine handshakes use the same rule with the scheduler as requester.
  logic             en;
  logic             rdy;
  logic [KEY_W-1:0] key;
  logic [KEY_W-1:0] key_q;
  phase_t           phase;
  logic             err;

  logic       init_en,     ksa_en,     prga_en;
  logic       init_rdy,    ksa_rdy,    prga_rdy;
  logic [7:0] init_addr,   ksa_addr,   prga_addr;
  logic [7:0] init_wrdata, ksa_wrdata, prga_wrdata;
  logic       init_wren,   ksa_wren,   prga_wren;

  logic [7:0] s_addr;
  logic [7:0] s_wrdata;
  logic       s_wren;

  sched_state_t dbg_state;

  modport master (
    output en, key,
    output init_rdy, ksa_rdy, prga_rdy,
    output init_addr, ksa_addr, prga_addr,
    output init_wrdata, ksa_wrdata, prga_wrdata,
    output init_wren, ksa_wren, prga_wren,
    input  rdy, key_q, phase, err,
    input  init_en, ksa_en, prga_en,
    input  s_addr, s_wrdata, s_wren,
    input  dbg_state
  );

  modport slave (
    input  en, key,
    input  init_rdy, ksa_rdy, prga_rdy,
    input  init_addr, ksa_addr, prga_addr,
    input  init_wrdata, ksa_wrdata, prga_wrdata,
    input  init_wren, ksa_wren, prga_wren,
    output rdy, key_q, phase, err,
    output init_en, ksa_en, prga_en,
    output s_addr, s_wrdata, s_wren,
    output dbg_state
  );

endinterface

// File: rtl/arc4_smem_mux.sv
// Combinational S-memory port mux: the engine owning the current phase drives the port.
module arc4_smem_mux
  import arc4_pkg::*;
(
  input  phase_t     phase,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_wrdata,
  input  logic       init_wren,
  input  logic [7:0] ksa_addr,
  input  logic [7:0] ksa_wrdata,
  input  logic       ksa_wren,
  input  logic [7:0] prga_addr,
  input  logic [7:0] prga_wrdata,
  input  logic       prga_wren,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren
);

  // Idle drives an all-zero, write-disabled port so no stray engine write lands.
  always_comb begin
    s_addr   = 8'd0;
    s_wrdata = 8'd0;
    s_wren   = 1'b0;
    case (phase)
      PH_INIT: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      PH_KSA: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      PH_PRGA: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 decrypt sequencer: runs init, ksa, prga once per request and owns the S-memory port.
// Optional per-phase watchdog enabled by defining ARC4_PHASE_TIMEOUT_EN.
module arc4_sched
  import arc4_pkg::*;
#(
  parameter int KEY_W          = KEY_W_DEF,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic         clk,
  input logic         rst_n,
  arc4_sched_if.slave bus
);

  sched_state_t     state;
  phase_t           phase_r;
  logic             rdy_r;
  logic             arm;
  logic             init_en_r, ksa_en_r, prga_en_r;
  logic [KEY_W-1:0] key_q_r;
  logic             tmo;

`ifdef ARC4_PHASE_TIMEOUT_EN
  logic [15:0] cnt;
  logic        err_r;

  // cnt holds (cycles spent in this phase - 1), so the abort lands on the edge
  // that closes the TIMEOUT_CYCLES-th cycle.
  assign tmo     = (state != IDLE) && (cnt == 16'(TIMEOUT_CYCLES - 1));
  assign bus.err = err_r;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo     = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase_r   <= PH_IDLE;
      rdy_r     <= 1'b1;
      arm       <= 1'b0;
      key_q_r   <= '0;
      init_en_r <= 1'b0;
      ksa_en_r  <= 1'b0;
      prga_en_r <= 1'b0;
`ifdef ARC4_PHASE_TIMEOUT_EN
      cnt       <= '0;
      err_r     <= 1'b0;
`endif
    end else begin
      init_en_r <= 1'b0;
      ksa_en_r  <= 1'b0;
      prga_en_r <= 1'b0;
`ifdef ARC4_PHASE_TIMEOUT_EN
      if (state != IDLE) cnt <= cnt + 16'd1;
`endif
      if (tmo) begin
        state   <= IDLE;
        phase_r <= PH_IDLE;
        rdy_r   <= 1'b1;
`ifdef ARC4_PHASE_TIMEOUT_EN
        err_r   <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: if (bus.en && rdy_r) begin
            key_q_r <= bus.key;
            rdy_r   <= 1'b0;
            phase_r <= PH_INIT;
            state   <= GO_INIT;
`ifdef ARC4_PHASE_TIMEOUT_EN
            cnt     <= '0;
            err_r   <= 1'b0;
`endif
          end
          GO_INIT: if (bus.init_rdy) begin
            init_en_r <= 1'b1;
            arm       <= 1'b0;
            state     <= RUN_INIT;
          end
          // First RUN cycle only arms: the engine's rdy is still the pre-start value.
          RUN_INIT: if (!arm) begin
            arm <= 1'b1;
          end else if (bus.init_rdy) begin
            phase_r <= PH_KSA;
            state   <= GO_KSA;
`ifdef ARC4_PHASE_TIMEOUT_EN
            cnt     <= '0;
`endif
          end
          GO_KSA: if (bus.ksa_rdy) begin
            ksa_en_r <= 1'b1;
            arm      <= 1'b0;
            state    <= RUN_KSA;
          end
          RUN_KSA: if (!arm) begin
            arm <= 1'b1;
          end else if (bus.ksa_rdy) begin
            phase_r <= PH_PRGA;
            state   <= GO_PRGA;
`ifdef ARC4_PHASE_TIMEOUT_EN
            cnt     <= '0;
`endif
          end
          GO_PRGA: if (bus.prga_rdy) begin
            prga_en_r <= 1'b1;
            arm       <= 1'b0;
            state     <= RUN_PRGA;
          end
          RUN_PRGA: if (!arm) begin
            arm <= 1'b1;
          end else if (bus.prga_rdy) begin
            phase_r <= PH_IDLE;
            rdy_r   <= 1'b1;
            state   <= IDLE;
          end
          default: begin
            phase_r <= PH_IDLE;
            rdy_r   <= 1'b1;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rdy       = rdy_r;
  assign bus.phase     = phase_r;
  assign bus.key_q     = key_q_r;
  assign bus.init_en   = init_en_r;
  assign bus.ksa_en    = ksa_en_r;
  assign bus.prga_en   = prga_en_r;
  assign bus.dbg_state = state;

  arc4_smem_mux u_smem_mux (
    .phase       (phase_r),
    .init_addr   (bus.init_addr),
    .init_wrdata (bus.init_wrdata),
    .init_wren   (bus.init_wren),
    .ksa_addr    (bus.ksa_addr),
    .ksa_wrdata  (bus.ksa_wrdata),
    .ksa_wren    (bus.ksa_wren),
    .prga_addr   (bus.prga_addr),
    .prga_wrdata (bus.prga_wrdata),
    .prga_wren   (bus.prga_wren),
    .s_addr      (bus.s_addr),
    .s_wrdata    (bus.s_wrdata),
    .s_wren      (bus.s_wren)
  );

endmodule

// File: tb/tb_arc4_sched.sv
// Bench for arc4_sched: stub engines, random S-port traffic, and a job-level reference model.
module tb_arc4_sched;
  import arc4_pkg::*;

`ifdef ARC4_PHASE_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif
  localparam int TMO = 100;
  localparam int KW  = 24;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arc4_sched_if #(.KEY_W(KW)) bus ();
  arc4_sched #(.KEY_W(KW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- stub engines ----------------
  int   cfg_len  [1:3];
  int   cfg_hold [1:3];
  bit   cfg_hang [1:3];
  logic st_rdy   [1:3];
  int   st_busy  [1:3];
  int   st_hold  [1:3];
  logic eng_en   [1:3];

  assign eng_en[1]    = bus.init_en;
  assign eng_en[2]    = bus.ksa_en;
  assign eng_en[3]    = bus.prga_en;
  assign bus.init_rdy = st_rdy[1];
  assign bus.ksa_rdy  = st_rdy[2];
  assign bus.prga_rdy = st_rdy[3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= 3; i++) begin
        st_rdy[i]  <= (cfg_hold[i] == 0);
        st_hold[i] <= cfg_hold[i];
        st_busy[i] <= 0;
      end
    end else begin
      for (int i = 1; i <= 3; i++) begin
        if (st_hold[i] > 0) begin
          st_hold[i] <= st_hold[i] - 1;
          if (st_hold[i] == 1) st_rdy[i] <= 1'b1;
        end else if (eng_en[i]) begin
          st_rdy[i]  <= 1'b0;
          st_busy[i] <= cfg_len[i];
        end else if (st_busy[i] > 0 && !cfg_hang[i]) begin
          st_busy[i] <= st_busy[i] - 1;
          if (st_busy[i] == 1) st_rdy[i] <= 1'b1;
        end
      end
    end
  end

  // Random S-port traffic from every engine, with overrides for directed cases.
  bit force_init = 1'b0;
  bit all_wren   = 1'b0;
  always @(posedge clk) begin
    #2;
    bus.init_addr   = 8'($urandom_range(0, 255));
    bus.init_wrdata = 8'($urandom_range(0, 255));
    bus.init_wren   = 1'($urandom_range(0, 1));
    bus.ksa_addr    = 8'($urandom_range(0, 255));
    bus.ksa_wrdata  = 8'($urandom_range(0, 255));
    bus.ksa_wren    = 1'($urandom_range(0, 1));
    bus.prga_addr   = 8'($urandom_range(0, 255));
    bus.prga_wrdata = 8'($urandom_range(0, 255));
    bus.prga_wren   = 1'($urandom_range(0, 1));
    if (force_init) begin
      bus.init_wren = 1'b1;
      bus.init_addr = 8'h55;
    end
    if (all_wren) begin
      bus.init_wren = 1'b1;
      bus.ksa_wren  = 1'b1;
      bus.prga_wren = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  // A job is: accept, then for each engine in turn wait for it to be free, start it,
  // and move on when it reports done. exp_q lists the engine starts still owed.
  int             m_phase;
  logic [KW-1:0]  m_key;
  bit             m_err;
  bit             m_started;
  logic [2:0]     m_en;
  int             m_cnt;
  int             m_jobs = 0;
  logic [1:0]     exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase   = 0;
      m_key     = '0;
      m_err     = 1'b0;
      m_started = 1'b0;
      m_en      = 3'b000;
      m_cnt     = 0;
      exp_q.delete();
    end else begin : step
      logic [2:0] en_now;
      en_now = m_en;
      m_en   = 3'b000;
      if (m_phase == 0) begin
        if (bus.en) begin
          m_phase   = 1;
          m_key     = bus.key;
          m_err     = 1'b0;
          m_cnt     = 0;
          m_started = 1'b0;
          m_jobs++;
          exp_q.push_back(2'd1);
          exp_q.push_back(2'd2);
          exp_q.push_back(2'd3);
        end
      end else begin
        m_cnt++;
        if (TMO_ON && m_cnt == TMO) begin
          m_phase   = 0;
          m_err     = 1'b1;
          m_started = 1'b0;
          exp_q.delete();
        end else if (!m_started) begin
          if (st_rdy[m_phase]) begin
            m_en[m_phase-1] = 1'b1;
            m_started       = 1'b1;
          end
        end else if (!en_now[m_phase-1] && st_rdy[m_phase]) begin
          m_started = 1'b0;
          m_phase   = (m_phase == 3) ? 0 : m_phase + 1;
          m_cnt     = 0;
        end
      end
    end
  end

  // ---------------- scoreboard (mid-cycle) ----------------
  int ph_prev = 0;
  int n_en [1:3] = '{0, 0, 0};
  int n_rdy_hi = 0;

  always @(negedge clk) begin : chk
    logic [7:0] ea, ed;
    logic       ew;
    logic [1:0] want;
    if (rst_n) begin
      case (m_phase)
        1:       begin ea = bus.init_addr; ed = bus.init_wrdata; ew = bus.init_wren; end
        2:       begin ea = bus.ksa_addr;  ed = bus.ksa_wrdata;  ew = bus.ksa_wren;  end
        3:       begin ea = bus.prga_addr; ed = bus.prga_wrdata; ew = bus.prga_wren; end
        default: begin ea = 8'd0;          ed = 8'd0;            ew = 1'b0;          end
      endcase
      check_eq("rdy",      bus.rdy,      (m_phase == 0));
      check_eq("phase",    bus.phase,    m_phase);
      check_eq("key_q",    bus.key_q,    m_key);
      check_eq("err",      bus.err,      m_err);
      check_eq("init_en",  bus.init_en,  m_en[0]);
      check_eq("ksa_en",   bus.ksa_en,   m_en[1]);
      check_eq("prga_en",  bus.prga_en,  m_en[2]);
      check_eq("s_addr",   bus.s_addr,   ea);
      check_eq("s_wrdata", bus.s_wrdata, ed);
      check_eq("s_wren",   bus.s_wren,   ew);

      if (ph_prev != m_phase) begin
        if (ph_prev == 3 && m_phase == 0 && !m_err)
          for (int i = 1; i <= 3; i++) check_eq("en_pulses", n_en[i], 1);
        if (ph_prev == 0)
          for (int i = 1; i <= 3; i++) n_en[i] = 0;
        ph_prev = m_phase;
      end
      for (int i = 1; i <= 3; i++) begin
        if (eng_en[i]) begin
          n_en[i]++;
          want = 2'd0;
          if (exp_q.size() > 0) want = exp_q.pop_front();
          check_eq("en_order", i, want);
        end
      end
      if (bus.en && bus.rdy) n_rdy_hi++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start_job(input logic [KW-1:0] k);
    bus.key = k;
    bus.en  = 1'b1;
    tick();
    bus.en  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (bus.rdy && m_phase == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, ok, 1);
  endtask

  task automatic rand_lens();
    for (int i = 1; i <= 3; i++) cfg_len[i] = $urandom_range(1, 60);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit reached;
    int base;
    bus.en  = 1'b0;
    bus.key = '0;
    for (int i = 1; i <= 3; i++) begin
      cfg_hold[i] = 0;
      cfg_hang[i] = 1'b0;
    end
    cfg_len[1] = TMO_ON ? 40 : 256;
    cfg_len[2] = TMO_ON ? 60 : 768;
    cfg_len[3] = TMO_ON ? 30 : 50;

    // reset values
    #9;
    check_eq("rst_rdy",      bus.rdy,      1);
    check_eq("rst_phase",    bus.phase,    0);
    check_eq("rst_key_q",    bus.key_q,    0);
    check_eq("rst_err",      bus.err,      0);
    check_eq("rst_init_en",  bus.init_en,  0);
    check_eq("rst_ksa_en",   bus.ksa_en,   0);
    check_eq("rst_prga_en",  bus.prga_en,  0);
    check_eq("rst_s_addr",   bus.s_addr,   0);
    check_eq("rst_s_wrdata", bus.s_wrdata, 0);
    check_eq("rst_s_wren",   bus.s_wren,   0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();

    // 1: full job with the reference key
    start_job(24'h000018);
    wait_idle("t1_done", 5000);
    check_eq("t1_key_q", bus.key_q, 24'h000018);

    // 2: init engine busy after reset; start must wait for it
    rand_lens();
    cfg_hold[1] = 10;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    start_job(KW'($urandom));
    tick(4);
    check_eq("t2_go_wait_phase", bus.phase, 1);
    check_eq("t2_go_wait_en", bus.init_en, 0);
    wait_idle("t2_done", 2000);
    cfg_hold[1] = 0;

    // 3: a non-owner hammering writes never reaches S; idle gates all writes
    rand_lens();
    force_init = 1'b1;
    start_job(KW'($urandom));
    wait_idle("t3_done", 2000);
    force_init = 1'b0;
    all_wren   = 1'b1;
    tick(6);
    check_eq("t3_idle_wren", bus.s_wren, 0);
    all_wren   = 1'b0;

    // 4: asynchronous reset mid-KSA, then a clean restart
    rand_lens();
    start_job(KW'($urandom));
    reached = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (m_phase == 2) begin
        reached = 1'b1;
        break;
      end
    end
    check_eq("t4_reach_ksa", reached, 1);
    tick(2);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t4_rst_rdy",     bus.rdy,     1);
    check_eq("t4_rst_phase",   bus.phase,   0);
    check_eq("t4_rst_init_en", bus.init_en, 0);
    check_eq("t4_rst_ksa_en",  bus.ksa_en,  0);
    check_eq("t4_rst_prga_en", bus.prga_en, 0);
    check_eq("t4_rst_s_wren",  bus.s_wren,  0);
    tick(2);
    rst_n = 1'b1;
    tick();
    start_job(KW'($urandom));
    wait_idle("t4_restart_done", 2000);

    // 5: en held high with a moving key: one job per rdy window, back to back
    rand_lens();
    n_rdy_hi = 0;
    base     = m_jobs;
    bus.key  = KW'($urandom);
    bus.en   = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      bus.key = KW'($urandom);
      if (m_jobs == base + 2) break;
    end
    bus.en = 1'b0;
    wait_idle("t5_done", 2000);
    check_eq("t5_accept_windows", n_rdy_hi, 2);

`ifdef ARC4_PHASE_TIMEOUT_EN
    // 6: prga never finishes; watchdog aborts, next request clears err
    rand_lens();
    cfg_hang[3] = 1'b1;
    start_job(KW'($urandom));
    wait_idle("t6_abort", 1000);
    check_eq("t6_err_set", bus.err, 1);
    cfg_hang[3] = 1'b0;
    tick(cfg_len[3] + 2);
    start_job(KW'($urandom));
    check_eq("t6_err_clr", bus.err, 0);
    wait_idle("t6_done", 2000);
`endif

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arc4_sched.md
Name: arc4_sched

Overview:
- Top-level sequencer for the ARC4 decrypt flow: runs init, then ksa, then prga, each exactly once per request.
- Sole arbiter of the single-port S memory (256x8): routes address, write data and write enable from whichever engine owns the current phase.
- Sits between the board wrapper (key from switches, start from KEY) and the three engines. The ct and pt memories remain private to prga and are not arbitrated here.

Parameters:
- KEY_W, 24, width of the ARC4 key.
- TIMEOUT_CYCLES, 65535, per-phase watchdog limit in clk cycles; used only with ARC4_PHASE_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  1 = idle and able to accept en
- key  in  KEY_W  key, latched on accepted en
- key_q  out  KEY_W  latched key, broadcast to ksa and prga
- phase  out  2  0 idle, 1 init, 2 ksa, 3 prga (for LEDR)
- err  out  1  sticky watchdog error (tied 0 when the feature is off)
- init_en / ksa_en / prga_en  out  1 each  one-cycle start pulse per engine
- init_rdy / ksa_rdy / prga_rdy  in  1 each  engine ready
- init_addr / ksa_addr / prga_addr  in  8 each  engine S address
- init_wrdata / ksa_wrdata / prga_wrdata  in  8 each  engine S write data
- init_wren / ksa_wren / prga_wren  in  1 each  engine S write enable
- s_addr  out  8  to S memory
- s_wrdata  out  8  to S memory
- s_wren  out  1  to S memory

S memory read data goes directly to all engines and does not pass through this block.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, rdy=1, phase=0, err=0, key_q=0.
  - All *_en=0, s_addr=0, s_wrdata=0, s_wren=0.
  - Reset mid-phase aborts immediately. Engines are reset by the same rst_n.
- Handshake (identical on both sides):
  - en is honoured only when rdy=1 in that cycle.
  - rdy falls the cycle after acceptance and rises when the whole job is complete.
  - en while rdy=0 is ignored.
- FSM states: IDLE, GO_INIT, RUN_INIT, GO_KSA, RUN_KSA, GO_PRGA, RUN_PRGA.
  - IDLE: on en, latch key into key_q, go to GO_INIT.
  - GO_x: wait until x_rdy=1. Then assert x_en for exactly one cycle, go to RUN_x, clear the arm flag.
  - RUN_x, first cycle: ignore x_rdy (the engine drops rdy one cycle after en) and set the arm flag.
  - RUN_x, later cycles: x_rdy=1 with the arm flag set advances to the next phase. RUN_PRGA returns to IDLE.
- Latency: rdy=1 reappears 1 cycle after prga_rdy rises. Minimum 2 overhead cycles per phase.
- Phase encoding: phase=1 in GO_INIT/RUN_INIT, 2 in the KSA states, 3 in the PRGA states, 0 in IDLE.
- S memory arbitration:
  - Combinational mux selected by the registered phase.
  - Phase 0 forces s_wren=0 and s_addr/s_wrdata=0.
  - A non-owner's wren never reaches s_wren, including wren asserted during GO_x of a different engine.
- key_q is held stable from acceptance until the next accepted en. Changes on key mid-job have no effect.
- Back-to-back jobs: en in the same cycle rdy returns to 1 is accepted.

Optional Feature:
- Macro: ARC4_PHASE_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter clears on entry to each GO_x and increments every cycle in GO_x/RUN_x.
  - When the counter reaches TIMEOUT_CYCLES: set err=1, drop any pending x_en, return to IDLE (rdy=1).
  - err stays set until the next accepted en, which clears it.
- Without the macro: no counter is built, err is tied 0, and phases wait indefinitely.

Decomposition:
- arc4_pkg holds:
  - sched_state_t enum
  - phase_t (2-bit) with constants PH_IDLE, PH_INIT, PH_KSA, PH_PRGA
  - KEY_W default
- One sub-module, arc4_smem_mux: a purely combinational 3-way S-port mux indexed by phase_t, including the phase-0 gating.

Test Plan:
1. Reset release with stub engines (rdy=1, done after 256/768/N cycles), en pulse, key=24'h000018 -> init_en, ksa_en, prga_en each pulse once in order; key_q=24'h000018; phase steps 0,1,2,3,0; rdy returns 1 one cycle after prga_rdy rises.
2. Stub init holds init_rdy=0 for 10 cycles after reset -> init_en is not asserted until init_rdy=1; no phase advance occurs while RUN_INIT observes a stale init_rdy=1 in its first cycle.
3. During RUN_KSA, init stub drives init_wren=1, init_addr=8'h55 -> s_wren and s_addr follow the ksa inputs only. In IDLE, all wren=1 -> s_wren=0.
4. Assert rst_n=0 mid-RUN_KSA (asynchronously, between clock edges) -> rdy=1, phase=0, all *_en=0, s_wren=0 in the same cycle. After release, a new en restarts from init.
5. en held high continuously and key changed during the job -> exactly one job runs with the first key; a second job starts on the cycle rdy rises.
6. With ARC4_PHASE_TIMEOUT_EN, TIMEOUT_CYCLES=100, prga stub never completes -> err=1 and rdy=1 at cycle 100 of the PRGA phase. The next en clears err.
